// File: rtl/uart_tx_fc_pkg.sv
// Shared UART definitions: line-rate defaults, frame width and transmitter state encodings.
package uart_tx_fc_pkg;

  localparam int CLK_HZ_DEFAULT = 12_000_000;
  localparam int BAUD_DEFAULT   = 2_000_000;
  localparam int DATA_BITS      = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
module uart_tx_fifo
  import uart_tx_fc_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic                 wr_en;
  logic                 rd_en;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fc.sv
// 8N1 UART transmitter with RTS/CTS flow control, fed from a small byte FIFO.
//
// state    | meaning
// TX_IDLE  | line high; pop next byte once FIFO non-empty and host ready
// TX_START | start bit (low) for one bit time
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (high) for one bit time
module uart_tx_fc
  import uart_tx_fc_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int BAUD    = BAUD_DEFAULT,
  parameter int FIFO_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 uart_rts,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 rts_meta_q, rts_s_q;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign uart_tx  = tx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !rts_s_q) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = BIT_LAST;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = BIT_LAST;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = BIT_LAST;
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_cnt_q == '0) state_d = TX_IDLE;
        else                 bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so the line lags the FSM by one clock.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != TX_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rts_meta_q <= 1'b1;
      rts_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rts_meta_q <= uart_rts;
      rts_s_q    <= rts_meta_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_fc.sv
// Scoreboard bench for uart_tx_fc: a mid-bit line receiver checks decoded frames against queued bytes.
`timescale 1ns/1ps
module tb_uart_tx_fc;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       uart_rts = 1'b1;
  logic       uart_tx;
  logic       busy;
  logic [4:0] fifo_level;

  uart_tx_fc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_rts   (uart_rts),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #42 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         frames_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  // Line receiver: start detected at first low sample, then each bit sampled at its centre.
  initial begin : monitor
    logic [7:0] b;
    logic       st;
    logic       sp;
    bit         ab;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        b  = 8'h00;
        wait_neg(3, ab);
        st = uart_tx;
        for (int k = 0; k < 8; k++) begin
          wait_neg(6, ab);
          b[k] = uart_tx;
        end
        wait_neg(6, ab);
        sp = uart_tx;
        if (!ab) begin
          check("start_bit", 32'(st), 32'(0));
          check("stop_bit", 32'(sp), 32'(1));
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %02h, no byte expected", b);
          end else begin
            check("frame_data", 32'(b), 32'(exp_q.pop_front()));
          end
          frame_starts.push_back(t0);
          frames_seen++;
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] d, input bit track, output int acc_cyc);
    int budget;
    budget   = 2000;
    acc_cyc  = -1;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      if (track) exp_q.push_back(d);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(frames_seen), 32'(target));
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  initial begin : watchdog
    #(84 * 40000);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int acc2;
    int base;
    int t;
    int lows;
    int n0;

    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'(1));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    rst_n    = 1'b1;
    uart_rts = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single byte, latency, busy
    base = frames_seen;
    push_byte(8'hA5, 1'b1, acc);
    wait_cyc(acc + 30);
    check("t1_busy_mid", 32'(busy), 32'(1));
    wait_frames(base + 1, 200, "t1_frames");
    if (frame_starts.size() > 0) begin
      t = frame_starts[frame_starts.size() - 1];
      check("t1_latency", 32'(t - acc), 32'(2));
      wait_cyc(t + 59);
      check("t1_busy_in_stop", 32'(busy), 32'(1));
      wait_cyc(t + 66);
      check("t1_busy_after", 32'(busy), 32'(0));
      check("t1_idle_line", 32'(uart_tx), 32'(1));
    end

    // 2: held by rts, then three back-to-back frames
    uart_rts = 1'b1;
    repeat (4) @(negedge clk);
    base = frames_seen;
    push_byte(8'h00, 1'b1, acc);
    push_byte(8'h01, 1'b1, acc);
    push_byte(8'h02, 1'b1, acc);
    count_low(40, lows);
    check("t2_line_held", 32'(lows), 32'(0));
    check("t2_level", 32'(fifo_level), 32'(3));
    check("t2_no_frames", 32'(frames_seen), 32'(base));
    n0 = frame_starts.size();
    uart_rts = 1'b0;
    wait_frames(base + 3, 400, "t2_frames");
    if (frame_starts.size() >= n0 + 3) begin
      check("t2_gap1", 32'(frame_starts[n0 + 1] - frame_starts[n0]), 32'(61));
      check("t2_gap2", 32'(frame_starts[n0 + 2] - frame_starts[n0 + 1]), 32'(61));
    end

    // 3: rts raised during bit 3
    repeat (10) @(negedge clk);
    base = frames_seen;
    push_byte(8'h3C, 1'b1, acc);
    wait_cyc(acc + 28);
    uart_rts = 1'b1;
    push_byte(8'h55, 1'b1, acc2);
    repeat (150) @(negedge clk);
    check("t3_one_frame", 32'(frames_seen), 32'(base + 1));
    check("t3_level_held", 32'(fifo_level), 32'(1));
    check("t3_line_idle", 32'(uart_tx), 32'(1));
    uart_rts = 1'b0;
    wait_frames(base + 2, 200, "t3_frames");

    // 4: fill to 16, overflow held off, drain
    repeat (10) @(negedge clk);
    uart_rts = 1'b1;
    repeat (4) @(negedge clk);
    base = frames_seen;
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b1, acc);
    in_data  = 8'h20;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_full_ready", 32'(in_ready), 32'(0));
    check("t4_full_level", 32'(fifo_level), 32'(16));
    uart_rts = 1'b0;
    for (int i = 16; i < 20; i++) push_byte(8'h10 + 8'(i), 1'b1, acc);
    wait_frames(base + 20, 20 * 61 + 300, "t4_frames");

    // 5: reset mid-frame
    repeat (10) @(negedge clk);
    base = frames_seen;
    push_byte(8'hFF, 1'b0, acc);
    wait_cyc(acc + 28);
    #10;
    rst_n = 1'b0;
    #1;
    check("t5_tx_in_reset", 32'(uart_tx), 32'(1));
    check("t5_level_in_reset", 32'(fifo_level), 32'(0));
    check("t5_ready_in_reset", 32'(in_ready), 32'(1));
    check("t5_busy_in_reset", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_low(100, lows);
    check("t5_quiet_after", 32'(lows), 32'(0));
    check("t5_no_frames", 32'(frames_seen), 32'(base));
    check("t5_busy_after", 32'(busy), 32'(0));
    push_byte(8'h81, 1'b1, acc);
    wait_frames(base + 1, 200, "t5_frames");

    // 6: push and pop in the same cycle at level 1
    repeat (10) @(negedge clk);
    base = frames_seen;
    push_byte(8'h5A, 1'b1, acc);
    push_byte(8'hC3, 1'b1, acc2);
    check("t6_back_to_back", 32'(acc2 - acc), 32'(1));
    check("t6_level", 32'(fifo_level), 32'(1));
    wait_frames(base + 2, 300, "t6_frames");

    repeat (10) @(negedge clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
